// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type, lane masks and fault check for lsu_mem_master.
// Optional build macro LSU_SUBWORD_EN enables byte/half accesses; without it only aligned words are legal.
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
    localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WRITE, ST_RESP} state_t;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
`ifdef LSU_SUBWORD_EN
        return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? lo[0] : size == SZ_WORD ? lo != 2'b00 : 1'b1;
`else
        return size != SZ_WORD || lo != 2'b00;
`endif
    endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: core request/response and byte-array memory signals of the LSU.
// master modport = LSU side (accepts requests, drives memory); slave modport = core/memory side.
interface lsu_mem_master_if #(parameter int ADDR_WIDTH = 32);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_fault;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wd;
    logic [31:0]           mem_rd;
    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wd
    );
    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational load lane extract/extend and store lane merge.
// Ports: size/lo/sgn describe the access, rd is the memory word, wd the right-justified store data;
// ld is the extended load value, st the merged write word. Sub-word logic exists only with LSU_SUBWORD_EN.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        sgn,
    input  logic [31:0] rd,
    input  logic [31:0] wd,
    output logic [31:0] ld,
    output logic [31:0] st
);
`ifdef LSU_SUBWORD_EN
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;
    always_comb begin
        sh      = size == SZ_HALF ? {lo[1], 4'b0000} : {lo, 3'b000};
        shifted = rd >> sh;
        ld      = size == SZ_BYTE ? {{24{sgn & shifted[7]}}, shifted[7:0]}
                : size == SZ_HALF ? {{16{sgn & shifted[15]}}, shifted[15:0]} : rd;
        mask    = (size == SZ_BYTE ? BYTE_MASK : HALF_MASK) << sh;
        // untouched lanes come from the word read in the same cycle
        st      = size == SZ_WORD ? wd : (rd & ~mask) | ((wd << sh) & mask);
    end
`else
    logic unused_sub;
    assign unused_sub = ^{size, lo, sgn};
    assign ld = rd;
    assign st = wd;
`endif
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store unit driving a combinational byte-array memory.
// Ports: clk, reset (async, active-high), bus (lsu_mem_master_if.master: core req/resp + memory).
// Build macro LSU_SUBWORD_EN enables byte/half accesses; otherwise they fault.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    lsu_mem_master_if.master   bus
);
    state_t                state, nxt;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [1:0]            size_q;
    logic                  sgn_q, we_q, fault_q;
    logic [31:0]           wd_q, rdata_q, wbuf_q;
    logic [31:0]           ld, st;
    logic                  fault_now;

    assign fault_now = misaligned(bus.req_size, bus.req_addr[1:0]);

    lsu_lane_align u_align (
        .size (size_q),
        .lo   (a_q[1:0]),
        .sgn  (sgn_q),
        .rd   (bus.mem_rd),
        .wd   (wd_q),
        .ld   (ld),
        .st   (st)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_IDLE;
        else state <= nxt;

    always_comb begin
        nxt            = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                nxt = bus.req_valid ? (fault_now ? ST_RESP : ST_ACCESS) : ST_IDLE;
            end
            ST_ACCESS: begin
                bus.mem_addr = {a_q[ADDR_WIDTH-1:2], 2'b00};
                nxt = we_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                bus.mem_addr = {a_q[ADDR_WIDTH-1:2], 2'b00};
                bus.mem_we   = 1'b1;
                nxt = ST_RESP;
            end
            default: begin
                bus.resp_valid = 1'b1;
                nxt = bus.resp_ready ? ST_IDLE : ST_RESP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
            wbuf_q  <= '0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                a_q     <= bus.req_addr;
                size_q  <= bus.req_size;
                sgn_q   <= bus.req_signed;
                we_q    <= bus.req_we;
                wd_q    <= bus.req_wdata;
                fault_q <= fault_now;
                rdata_q <= '0;
            end
            if (state == ST_ACCESS) begin
                if (we_q) wbuf_q <= st;
                else rdata_q <= ld;
            end
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
    assign bus.mem_wd     = wbuf_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed vector bench for lsu_mem_master with a small word memory model.
module tb_lsu_mem_master;
    import lsu_pkg::*;
`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          writes;
        logic [31:0] wd;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic init_mem;
    logic [31:0] mem [0:15];
    vec_t v [13];
    vec_t t_end;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_mem_master_if #(.ADDR_WIDTH(32)) bus ();
    lsu_mem_master #(.ADDR_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.mem_rd = mem[bus.mem_addr[5:2]];

    always @(posedge clk)
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h8899aabb;
            mem[12] <= 32'hcafef00d;
        end else if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input int idx, input int hold);
        int lat = 0;
        int writes = 0;
        logic [31:0] wd_seen = 0;
        logic [31:0] wa_seen = 0;
        bit got = 0;
        @(negedge clk);
        chk($sformatf("v%0d req_ready", idx), {31'b0, bus.req_ready}, 32'd1);
        bus.req_we     = t.we;
        bus.req_size   = t.size;
        bus.req_signed = t.sgn;
        bus.req_addr   = t.addr;
        bus.req_wdata  = t.wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            bus.req_valid = 1'b0;
            if (bus.mem_we) begin
                writes++;
                wd_seen = bus.mem_wd;
                wa_seen = bus.mem_addr;
            end
            got = bus.resp_valid;
        end
        chk($sformatf("v%0d latency", idx), lat, t.lat);
        chk($sformatf("v%0d fault", idx), {31'b0, bus.resp_fault}, {31'b0, t.fault});
        chk($sformatf("v%0d rdata", idx), bus.resp_rdata, t.rdata);
        chk($sformatf("v%0d writes", idx), writes, t.writes);
        if (t.writes > 0) begin
            chk($sformatf("v%0d mem_wd", idx), wd_seen, t.wd);
            chk($sformatf("v%0d mem_addr", idx), wa_seen, {t.addr[31:2], 2'b00});
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("v%0d hold%0d resp_valid", idx, h), {31'b0, bus.resp_valid}, 32'd1);
            chk($sformatf("v%0d hold%0d rdata", idx, h), bus.resp_rdata, t.rdata);
            chk($sformatf("v%0d hold%0d req_ready", idx, h), {31'b0, bus.req_ready}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk($sformatf("v%0d ready after hs", idx), {31'b0, bus.req_ready}, 32'd1);
        chk($sformatf("v%0d valid after hs", idx), {31'b0, bus.resp_valid}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        chk({nm, " resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        chk({nm, " resp_fault"}, {31'b0, bus.resp_fault}, 32'd0);
        chk({nm, " resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({nm, " mem_we"}, {31'b0, bus.mem_we}, 32'd0);
        chk({nm, " mem_addr"}, bus.mem_addr, 32'd0);
        chk({nm, " mem_wd"}, bus.mem_wd, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        v[0]  = '{1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, SUB ? 32'hffffffaa : 32'h0, !SUB, SUB ? 2 : 1, 0, 32'h0};
        v[1]  = '{1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, SUB ? 32'h00008899 : 32'h0, !SUB, SUB ? 2 : 1, 0, 32'h0};
        v[2]  = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8899aabb, 1'b0, 2, 0, 32'h0};
        v[3]  = '{1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h5c, 32'h0, !SUB, SUB ? 3 : 1, SUB ? 1 : 0, 32'h5c99aabb};
        v[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, SUB ? 32'h5c99aabb : 32'h8899aabb, 1'b0, 2, 0, 32'h0};
        v[5]  = '{1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
        v[6]  = '{1'b1, SZ_HALF, 1'b0, 32'h05, 32'hffff, 32'h0, 1'b1, 1, 0, 32'h0};
        v[7]  = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
        v[8]  = '{1'b1, SZ_WORD, 1'b0, 32'h20, 32'hdeadbeef, 32'h0, 1'b0, 3, 1, 32'hdeadbeef};
        v[9]  = '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hdeadbeef, 1'b0, 2, 0, 32'h0};
        v[10] = '{1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, SUB ? 32'hffffdead : 32'h0, !SUB, SUB ? 2 : 1, 0, 32'h0};
        v[11] = '{1'b1, SZ_HALF, 1'b0, 32'h20, 32'h12345678, 32'h0, !SUB, SUB ? 3 : 1, SUB ? 1 : 0, 32'hdead5678};
        v[12] = '{1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, SUB ? 32'h00000056 : 32'h0, !SUB, SUB ? 2 : 1, 0, 32'h0};
        t_end = '{1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'hcafef00d, 1'b0, 2, 0, 32'h0};

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        init_mem       = 1'b1;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        init_mem = 1'b0;
        reset    = 1'b0;

        for (int i = 0; i < 13; i++) run(v[i], i, 0);
        run(v[4], 20, 5);

        // reset in the middle of a word store's write cycle
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h11112222;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst access mem_we", {31'b0, bus.mem_we}, 32'd0);
        @(negedge clk);
        chk("rst write mem_we", {31'b0, bus.mem_we}, 32'd1);
        #1 reset = 1'b1;
        #1 chk_reset_outputs("midwrite");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst target word", mem[12], 32'hcafef00d);
        run(t_end, 30, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
